fan_ramp_ctrl: RTL and testbench



---
 rtl/fan_ctrl_pkg.sv | 22 ++
 rtl/fan_tick_gen.sv | 35 +++
 rtl/fan_ramp_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fan_ramp_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the fan controller blocks.
package fan_ctrl_pkg;

  localparam int unsigned DUTY_W = 8;

  // Speed-level request encoding.
  localparam logic [1:0] LVL_OFF  = 2'd0;
  localparam logic [1:0] LVL_LOW  = 2'd1;
  localparam logic [1:0] LVL_MID  = 2'd2;
  localparam logic [1:0] LVL_FULL = 2'd3;

  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  typedef enum logic [2:0] {
    StIdle,
    StRampUp,
    StRampDown,
    StHold,
    StKick
  } fan_state_e;

endpackage

// File: rtl/fan_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clk_in cycles.
module fan_tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("fan_tick_gen: TICK_DIV must be at least 2");
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  // Wrap at TICK_DIV-1; requests never touch this counter.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fan_ramp_ctrl.sv
// Fan speed sequencer: accepts level requests, ramps duty one STEP per tick,
// and drives a registered PWM pin. Optional kickstart (full duty for
// KICK_TICKS ticks on spin-up from zero) is enabled by FAN_KICKSTART_EN.
module fan_ramp_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned STEP       = 8,
  parameter int unsigned LOW_DUTY   = 64,
  parameter int unsigned MID_DUTY   = 160,
  parameter int unsigned KICK_TICKS = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [1:0]        req_level,
  output logic              req_ready,
  input  logic              estop,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty_cur,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] StepV   = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] LowDuty = DUTY_W'(LOW_DUTY);
  localparam logic [DUTY_W-1:0] MidDuty = DUTY_W'(MID_DUTY);

  if (STEP < 1 || STEP > 255 || KICK_TICKS < 1) begin : g_bad_param
    $error("fan_ramp_ctrl: STEP must be 1..255 and KICK_TICKS at least 1");
  end

  function automatic logic [DUTY_W-1:0] level_duty(input logic [1:0] lvl);
    case (lvl)
      LVL_OFF:  return '0;
      LVL_LOW:  return LowDuty;
      LVL_MID:  return MidDuty;
      default:  return DUTY_MAX;
    endcase
  endfunction

  fan_state_e        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] pwm_cnt_q;
  logic              pwm_q;
  logic              tick;
  logic              accept;
  logic [DUTY_W-1:0] req_duty;

`ifdef FAN_KICKSTART_EN
  localparam int unsigned KickW = $clog2(KICK_TICKS + 1);
  localparam logic [KickW-1:0] KickLast = KickW'(KICK_TICKS - 1);
  logic [KickW-1:0] kick_cnt_q, kick_cnt_d;
`endif

  fan_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  assign req_ready = ((state_q == StIdle) || (state_q == StHold)) && !estop;
  assign accept    = req_valid && req_ready;
  assign req_duty  = level_duty(req_level);
  assign busy      = (state_q == StRampUp) || (state_q == StRampDown) || (state_q == StKick);
  assign duty_cur  = duty_q;
  assign pwm_out   = pwm_q;

  // Next-state: estop overrides everything; ramps advance only on tick.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
`ifdef FAN_KICKSTART_EN
    kick_cnt_d = kick_cnt_q;
`endif
    if (estop) begin
      state_d  = StIdle;
      duty_d   = '0;
      target_d = '0;
`ifdef FAN_KICKSTART_EN
      kick_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        StIdle, StHold: begin
          if (accept) begin
            target_d = req_duty;
`ifdef FAN_KICKSTART_EN
            if (duty_q == '0 && req_duty != '0) begin
              state_d    = StKick;
              duty_d     = DUTY_MAX;
              kick_cnt_d = '0;
            end else
`endif
            if (req_duty > duty_q) begin
              state_d = StRampUp;
            end else if (req_duty < duty_q) begin
              state_d = StRampDown;
            end else begin
              state_d = (req_duty == '0) ? StIdle : StHold;
            end
          end
        end
        StRampUp: begin
          if (tick) begin
            // target > duty here, so the difference cannot underflow.
            if ((target_q - duty_q) <= StepV) begin
              duty_d  = target_q;
              state_d = StHold;
            end else begin
              duty_d = duty_q + StepV;
            end
          end
        end
        StRampDown: begin
          if (tick) begin
            if ((duty_q - target_q) <= StepV) begin
              duty_d  = target_q;
              state_d = (target_q == '0) ? StIdle : StHold;
            end else begin
              duty_d = duty_q - StepV;
            end
          end
        end
`ifdef FAN_KICKSTART_EN
        StKick: begin
          if (tick) begin
            if (kick_cnt_q == KickLast) begin
              duty_d  = target_q;
              state_d = StHold;
            end else begin
              kick_cnt_d = kick_cnt_q + KickW'(1);
            end
          end
        end
`endif
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      duty_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
    end
  end

`ifdef FAN_KICKSTART_EN
  // Kickstart tick counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      kick_cnt_q <= '0;
    end else begin
      kick_cnt_q <= kick_cnt_d;
    end
  end
`endif

  // PWM: full duty forces constant high, otherwise compare against the counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
      pwm_q     <= (duty_q == DUTY_MAX) || (pwm_cnt_q < duty_q);
    end
  end

endmodule

// File: tb/tb_fan_ramp_ctrl.sv
// Self-checking bench for fan_ramp_ctrl (TICK_DIV=4, STEP=16). Also
// exercises the FAN_KICKSTART_EN build when that macro is defined.
module tb_fan_ramp_ctrl;

  localparam int TD  = 4;
  localparam int ST  = 16;
  localparam int LOW = 64;
  localparam int MID = 160;
  localparam int KT  = 4;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_level = 2'd0;
  logic       estop = 1'b0;
  logic       req_ready;
  logic       pwm_out;
  logic [7:0] duty_cur;
  logic       busy;

  int n_checks = 0;
  int n_pass = 0;
  int seen[$];

  always #5 clk_in = ~clk_in;

  fan_ramp_ctrl #(
    .TICK_DIV   (TD),
    .STEP       (ST),
    .LOW_DUTY   (LOW),
    .MID_DUTY   (MID),
    .KICK_TICKS (KT)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_level (req_level),
    .req_ready (req_ready),
    .estop     (estop),
    .pwm_out   (pwm_out),
    .duty_cur  (duty_cur),
    .busy      (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: duty chases target by STEP per tick; busy means the
  // duty has not yet settled on its target (or a kickstart is running).
  int m_duty, m_tgt, m_kick, m_tcnt, m_pcnt;
  bit m_pwm;
  bit m_busy, m_ready;

  function automatic int lvl_duty(input int lvl);
    case (lvl)
      0: return 0;
      1: return LOW;
      2: return MID;
      default: return 255;
    endcase
  endfunction

  always_comb begin
    m_busy  = (m_duty != m_tgt) || (m_kick > 0);
    m_ready = !m_busy && !estop;
  end

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_duty <= 0; m_tgt <= 0; m_kick <= 0; m_tcnt <= 0; m_pcnt <= 0; m_pwm <= 1'b0;
    end else begin
      automatic int d = m_duty;
      automatic int t = m_tgt;
      automatic int k = m_kick;
      automatic bit tk = (m_tcnt == TD - 1);
      m_pwm  <= (d == 255) || (m_pcnt < d);
      m_tcnt <= (m_tcnt + 1) % TD;
      m_pcnt <= (m_pcnt + 1) % 256;
      if (estop) begin
        d = 0; t = 0; k = 0;
      end else if (req_valid && m_ready) begin
        t = lvl_duty(int'(req_level));
`ifdef FAN_KICKSTART_EN
        if (d == 0 && t > 0) begin d = 255; k = KT; end
`endif
      end else if (tk) begin
        if (k > 0) begin
          k = k - 1;
          if (k == 0) d = t;
        end else if (d < t) begin
          d = (d + ST > t) ? t : d + ST;
        end else if (d > t) begin
          d = (d - ST < t) ? t : d - ST;
        end
      end
      m_duty <= d; m_tgt <= t; m_kick <= k;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_in) begin
    if (rst_n) begin
      check("duty_cur", int'(duty_cur), m_duty);
      check("pwm_out", int'(pwm_out), int'(m_pwm));
      check("busy", int'(busy), int'(m_busy));
      check("req_ready", int'(req_ready), int'(m_ready));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Present a request and hold it until accepted; returns at the negedge after acceptance.
  task automatic request(input int lvl);
    req_valid = 1'b1;
    req_level = 2'(lvl);
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin
        @(negedge clk_in);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk_in);
    end
    req_valid = 1'b0;
    check("request_timeout", 0, 1);
  endtask

  // Record each distinct duty value until the ramp completes.
  task automatic collect(input int start);
    int last = start;
    seen.delete();
    for (int i = 0; i < 600; i++) begin
      if (int'(duty_cur) != last) begin
        last = int'(duty_cur);
        seen.push_back(last);
      end
      if (!busy) return;
      @(negedge clk_in);
    end
    check("ramp_timeout", 0, 1);
  endtask

  task automatic count_pwm(input string name, input int exp);
    int hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_in);
      hi += int'(pwm_out);
    end
    check(name, hi, exp);
  endtask

  task automatic check_seen(input string name, input int exp[$]);
    check({name, "_len"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++) check(name, seen[i], exp[i]);
  endtask

  initial begin
    int exp_q[$];
    int kick_q[$];
    step(2);
    rst_n = 1'b1;
    step(20);
    check("reset_duty", int'(duty_cur), 0);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_ready", int'(req_ready), 1);
    check("reset_busy", int'(busy), 0);

    // 0 -> full: 16..240 then 255 on the 16th tick.
    request(3);
    collect(0);
    exp_q = {16, 32, 48, 64, 80, 96, 112, 128, 144, 160, 176, 192, 208, 224, 240, 255};
    check_seen("up_full", exp_q);
    step(2);
    count_pwm("pwm_full_high", 256);

    // 255 -> low: 239..79 then 64.
    request(1);
    collect(255);
    exp_q = {239, 223, 207, 191, 175, 159, 143, 127, 111, 95, 79, 64};
    check_seen("down_low", exp_q);
    step(2);
    count_pwm("pwm_low_high", 64);

    // Request held during a ramp is stalled, then taken on the first ready cycle.
    request(3);
    req_valid = 1'b1;
    req_level = 2'd2;
    for (int i = 0; i < 400 && !req_ready; i++) begin
      check("stall_not_ready", int'(req_ready), 0);
      @(negedge clk_in);
    end
    check("stall_duty_at_ready", int'(duty_cur), 255);
    @(negedge clk_in);
    req_valid = 1'b0;
    check("stall_accepted_busy", int'(busy), 1);
    collect(255);
    exp_q = {239, 223, 207, 191, 175, 160};
    check_seen("down_mid", exp_q);

    // estop at duty 128 while ramping down; a coincident request is refused.
    req_valid = 1'b1;
    req_level = 2'd0;
    for (int i = 0; i < 200 && int'(duty_cur) != 128; i++) begin
      @(negedge clk_in);
      if (!req_ready) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    check("estop_pre_duty", int'(duty_cur), 128);
    estop = 1'b1;
    req_valid = 1'b1;
    req_level = 2'd3;
    step(1);
    check("estop_duty", int'(duty_cur), 0);
    check("estop_busy", int'(busy), 0);
    check("estop_ready", int'(req_ready), 0);
    step(1);
    check("estop_pwm", int'(pwm_out), 0);
    step(4);
    req_valid = 1'b0;
    check("estop_hold_duty", int'(duty_cur), 0);
    estop = 1'b0;
    step(1);
    check("estop_release_ready", int'(req_ready), 1);
    request(0);
    step(20);
    check("off_req_duty", int'(duty_cur), 0);
    check("off_req_busy", int'(busy), 0);

    // Spin-up from zero to low: kickstart or plain ramp.
    request(1);
    collect(0);
`ifdef FAN_KICKSTART_EN
    kick_q = {255, 64};
`else
    kick_q = {16, 32, 48, 64};
`endif
    check_seen("spinup_low", kick_q);

    // Asynchronous reset mid-ramp clears outputs without waiting for a clock.
    request(3);
    step(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_duty", int'(duty_cur), 0);
    check("areset_pwm", int'(pwm_out), 0);
    check("areset_busy", int'(busy), 0);
    check("areset_ready", int'(req_ready), 1);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("post_reset_duty", int'(duty_cur), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
